// File: rtl/uiq_pkg.sv
// Shared issue-queue / writeback definitions: FU indices, tag width and the
// packed result record carried from an FU to the broadcast bus.
package uiq_pkg;

  localparam int AR_SIZE  = 7;
  localparam int FU_ARRAY = 3;
  localparam int FU_SIZE  = 2;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MEM  = 2;

  typedef struct packed {
    logic [AR_SIZE-1:0] tag;
    logic [31:0]        value;
  } wb_result_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular result buffer for one FU. Pushes while full and pops while
// empty are ignored, so the count always stays within 0..DEPTH.
module wb_result_fifo #(
  parameter  int WIDTH = 39,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Per-FU result FIFOs feeding one round-robin broadcast bus (UIQ wakeup + ROB).
// Define WB_BYPASS_EN to let an idle FU's fresh result skip its FIFO.
module writeback_arbiter #(
  parameter int FU_ARRAY   = uiq_pkg::FU_ARRAY,
  parameter int FU_SIZE    = uiq_pkg::FU_SIZE,
  parameter int AR_SIZE    = uiq_pkg::AR_SIZE,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FU_ARRAY-1:0]       fu_valid_in,
  input  logic [FU_ARRAY*AR_SIZE-1:0] fu_tag_in,
  input  logic [FU_ARRAY*32-1:0]    fu_value_in,
  output logic [FU_ARRAY-1:0]       fu_ready_out,
  output logic                      reg_valid_out,
  output logic [AR_SIZE-1:0]        reg_tag_out,
  output logic [31:0]               reg_value_out,
  output logic [FU_SIZE-1:0]        reg_fu_out,
  output logic                      overflow_err_out
);

  localparam int RES_W = AR_SIZE + 32;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [RES_W-1:0]    in_data    [FU_ARRAY];
  logic [RES_W-1:0]    fifo_head  [FU_ARRAY];
  logic [CNT_W-1:0]    fifo_count [FU_ARRAY];
  logic [FU_ARRAY-1:0] fifo_full;
  logic [FU_ARRAY-1:0] fifo_empty;
  logic [FU_ARRAY-1:0] tag_nz;
  logic [FU_ARRAY-1:0] byp_cand;
  logic [FU_ARRAY-1:0] cand;
  logic [FU_ARRAY-1:0] push;
  logic [FU_ARRAY-1:0] pop;
  logic [FU_SIZE-1:0]  rr_ptr;
  logic [FU_SIZE-1:0]  grant_idx;
  logic                grant_valid;
  logic [RES_W-1:0]    grant_data;

  // Handshake: FU i's result transfers on a cycle where fu_valid_in[i] and
  // fu_ready_out[i] are both high; ready depends only on registered counts.
  always_comb begin
    for (int i = 0; i < FU_ARRAY; i++) begin
      in_data[i]      = {fu_tag_in[i*AR_SIZE +: AR_SIZE], fu_value_in[i*32 +: 32]};
      tag_nz[i]       = |fu_tag_in[i*AR_SIZE +: AR_SIZE];
      fu_ready_out[i] = !rst && (fifo_count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_cand = fifo_empty & fu_valid_in & fu_ready_out & tag_nz;
`else
  assign byp_cand = '0;
`endif

  assign cand = ~fifo_empty | byp_cand;

  // First candidate at or after the pointer, then wrap to those below it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    grant_data  = '0;
    for (int i = 0; i < FU_ARRAY; i++) begin
      if (!grant_valid && cand[i] && (FU_SIZE'(i) >= rr_ptr)) begin
        grant_valid = 1'b1;
        grant_idx   = FU_SIZE'(i);
        grant_data  = fifo_empty[i] ? in_data[i] : fifo_head[i];
      end
    end
    for (int i = 0; i < FU_ARRAY; i++) begin
      if (!grant_valid && cand[i] && (FU_SIZE'(i) < rr_ptr)) begin
        grant_valid = 1'b1;
        grant_idx   = FU_SIZE'(i);
        grant_data  = fifo_empty[i] ? in_data[i] : fifo_head[i];
      end
    end
  end

  // Tag 0 completes the handshake but is never stored; a bypassed result is
  // granted straight from the input and must not also be enqueued.
  always_comb begin
    for (int i = 0; i < FU_ARRAY; i++) begin
      pop[i]  = grant_valid && (grant_idx == FU_SIZE'(i)) && !fifo_empty[i];
      push[i] = fu_valid_in[i] && fu_ready_out[i] && tag_nz[i] &&
                !(grant_valid && (grant_idx == FU_SIZE'(i)) && fifo_empty[i]);
    end
  end

  for (genvar i = 0; i < FU_ARRAY; i++) begin : g_fifo
    wb_result_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data[i]),
      .pop       (pop[i]),
      .head_data (fifo_head[i]),
      .count     (fifo_count[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr           <= '0;
      reg_valid_out    <= 1'b0;
      reg_tag_out      <= '0;
      reg_value_out    <= '0;
      reg_fu_out       <= '0;
      overflow_err_out <= 1'b0;
    end else begin
      if (grant_valid) begin
        rr_ptr        <= (grant_idx == FU_SIZE'(FU_ARRAY - 1)) ? '0 : grant_idx + 1'b1;
        reg_valid_out <= 1'b1;
        {reg_tag_out, reg_value_out} <= grant_data;
        reg_fu_out    <= grant_idx;
      end else begin
        reg_valid_out <= 1'b0;
        reg_tag_out   <= '0;
        reg_value_out <= '0;
      end
      if (|(fu_valid_in & fifo_full)) overflow_err_out <= 1'b1;
    end
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Writeback stage directly downstream of the FUs fed by Unified_Issue_Queue. It buffers each FU's completed result (dest tag plus value) in a small per-FU FIFO. Each cycle it round-robin arbitrates one result onto the single broadcast bus, which drives UIQ reg_tag_from_FU_in/reg_value_from_FU_in wakeup and the ROB. It returns per-FU ready, and that ready drives UIQ fu_ready_from_FU_in.

Parameters:
FU_ARRAY, 3, number of FUs / result ports
FU_SIZE, 2, width of FU index (2^FU_SIZE >= FU_ARRAY)
AR_SIZE, 7, dest register tag width
FIFO_DEPTH, 2, entries per FU result FIFO (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
fu_valid_in  in  FU_ARRAY  FU i presents a result this cycle
fu_tag_in  in  FU_ARRAY*AR_SIZE  dest tag, FU i at [i*AR_SIZE +: AR_SIZE]
fu_value_in  in  FU_ARRAY*32  result value, FU i at [i*32 +: 32]
fu_ready_out  out  FU_ARRAY  FU i FIFO can accept; feeds UIQ fu_ready_from_FU_in
reg_valid_out  out  1  broadcast valid
reg_tag_out  out  AR_SIZE  broadcast tag; 0 when idle
reg_value_out  out  32  broadcast value; 0 when idle
reg_fu_out  out  FU_SIZE  index of the FU whose result is broadcast
overflow_err_out  out  1  sticky: a push was attempted while not ready

Behaviour:
- Reset (rst=1 at edge): all FIFOs emptied; RR pointer=0; reg_valid_out=0, reg_tag_out=0, reg_value_out=0, reg_fu_out=0; overflow_err_out=0. fu_ready_out forced all-0 while rst=1.
- fu_ready_out[i] = (count_i < FIFO_DEPTH), decoded combinationally from registered counts. It is conservative: a full FIFO is not-ready even if it pops this cycle.
- Push: fu_valid_in[i] & fu_ready_out[i] writes {tag,value} at the tail.
- Push with fu_valid_in[i] & !fu_ready_out[i]: the result is dropped, FIFO unchanged, overflow_err_out set until reset.
- Tag 0 (x0): accepted (handshake completes) but never enqueued or broadcast, because UIQ treats tag 0 as no-wakeup.
- Arbitration each cycle: candidates = non-empty FIFOs. Grant the first candidate at or after the RR pointer, modulo FU_ARRAY. On grant g, pop the head of FIFO g and set the pointer to (g+1) mod FU_ARRAY. With no candidate, the pointer is held.
- Output regs, loaded at the edge: granted head → reg_valid_out=1, tag, value, reg_fu_out=g. With no grant: reg_valid_out=0, tag=0, value=0, reg_fu_out held.
- Latency without bypass: result pushed at edge N, broadcast visible after edge N+1 (2 cycles from fu_valid_in). Throughput is 1 broadcast/cycle total.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved (pop old head, push at tail).
- Pointers wrap modulo FIFO_DEPTH. count range is 0..FIFO_DEPTH.
- Mid-operation reset: all buffered results are discarded, with no broadcast in the reset cycle or the cycle after.
- Per-FU order is strictly FIFO. Cross-FU order follows RR only.

Optional Feature:
WB_BYPASS_EN. If defined: an FU with an empty FIFO and a valid, ready, nonzero-tag input is also a candidate, competing under the same RR. If that FU is granted, the input goes straight to the output regs and is not enqueued, giving 1-cycle latency. An ungranted bypass candidate is enqueued normally. If undefined: only FIFO heads are candidates, with fixed 2-cycle latency.

Decomposition:
- Package uiq_pkg: AR_SIZE, FU_ARRAY, FU_SIZE, FU index constants (FU_ALU0=0, FU_ALU1=1, FU_MEM=2), and a packed wb_result_t {tag, value}. It is shared with Unified_Issue_Queue.
- Sub-module wb_result_fifo: one instance per FU, parameterised by FIFO_DEPTH. It has push/pop ports, head data, and count/full/empty outputs.
- The top level holds the RR arbiter and the output regs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0, fu_ready_out=000. After release → fu_ready_out=111, reg_valid_out=0.
- Single result: FU1 tag=4, value=0x5 at cycle 0 → reg_valid_out=1, tag=4, value=5, reg_fu_out=1 in cycle 2 (cycle 1 with WB_BYPASS_EN).
- Fairness: all 3 FUs valid in the same cycle with tags 2/3/8 → broadcasts on 3 consecutive cycles in order FU0,FU1,FU2. Repeat → order continues from the pointer.
- Backpressure: FU2 pushes every cycle with FIFO_DEPTH=2 while FU0/FU1 keep the arbiter busy → fu_ready_out[2]=0 once count=2, and no loss of data.
- Overflow and x0: FU0 valid while fu_ready_out[0]=0 → overflow_err_out=1 and stays 1. FU1 with tag=0 → never broadcast.
- Mid-op reset: 4 results buffered, rst=1 for 1 cycle → no broadcast of buffered data afterwards, counts=0.
